// File: rtl/cpu_types_pkg.sv
// Shared types and geometry for the data cache miss/flush controller.
package cpu_types_pkg;

  localparam int unsigned DSETS  = 8;
  localparam int unsigned DWAYS  = 2;
  localparam int unsigned TAG_W  = 26;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned WAY_W  = $clog2(DWAYS);
  localparam int unsigned FCNT_W = IDX_W + WAY_W;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    WB0  = 4'd1,
    WB1  = 4'd2,
    LD0  = 4'd3,
    LD1  = 4'd4,
    FCHK = 4'd5,
    FWB0 = 4'd6,
    FWB1 = 4'd7,
    DONE = 4'd8
  } dmc_state_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic             off;
    logic [1:0]       bytoff;
  } dcache_addr_t;

endpackage

// File: rtl/dcache_miss_ctrl.sv
// Miss handling (LRU victim, writeback, refill) and halt-time flush for the
// 2-way, 8-set, 2-word-block data cache.
module dcache_miss_ctrl
  import cpu_types_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  input  logic                dmemREN,
  input  logic                dmemWEN,
  input  logic [31:0]         dmemaddr,
  input  logic                miss,
  input  logic                setsel,
  input  logic                halt,
  output logic [IDX_W-1:0]    rd_idx,
  output logic                rd_way,
  input  logic                vic_valid,
  input  logic                vic_dirty,
  input  logic [TAG_W-1:0]    vic_tag,
  input  logic [31:0]         vic_data0,
  input  logic [31:0]         vic_data1,
  output logic                dREN,
  output logic                dWEN,
  output logic [31:0]         daddr,
  output logic [31:0]         dstore,
  input  logic                dwait,
  input  logic [31:0]         dload,
  output logic                fill_en,
  output logic                fill_off,
  output logic [31:0]         fill_data,
  output logic [TAG_W-1:0]    fill_tag,
  output logic                set_valid,
  output logic                clr_dirty,
  output logic                flushed
);

  dmc_state_t        state;
  logic [DSETS-1:0]  lru;
  logic [FCNT_W-1:0] fcnt;
  logic              vway;
  dcache_addr_t      req;
  logic              req_v;
  logic              vic_wb;
  logic              fcnt_last;
  logic              unused_addr_bits;

  assign req       = dcache_addr_t'(dmemaddr);
  assign req_v     = dmemREN | dmemWEN;
  assign vic_wb    = vic_valid & vic_dirty;
  assign fcnt_last = (fcnt == FCNT_W'(DSETS * DWAYS - 1));

  // Offset/byte bits never matter here: blocks are fetched whole.
  assign unused_addr_bits = ^{req.off, req.bytoff};

  // Controller state, LRU bits, flush counter and latched victim way.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      lru   <= '0;
      fcnt  <= '0;
      vway  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (halt) begin
            fcnt  <= '0;
            state <= FCHK;
          end else if (req_v) begin
            if (miss) begin
              vway  <= lru[req.idx];
              state <= vic_wb ? WB0 : LD0;
            end else begin
              lru[req.idx] <= ~setsel;
            end
          end
        end
        WB0:  if (!dwait) state <= WB1;
        WB1:  if (!dwait) state <= LD0;
        LD0:  if (!dwait) state <= LD1;
        LD1:  if (!dwait) state <= IDLE;
        FCHK: begin
          if (vic_wb) begin
            state <= FWB0;
          end else if (fcnt_last) begin
            state <= DONE;
          end else begin
            fcnt <= fcnt + FCNT_W'(1);
          end
        end
        FWB0: if (!dwait) state <= FWB1;
        FWB1: begin
          if (!dwait) begin
            if (fcnt_last) begin
              state <= DONE;
            end else begin
              fcnt  <= fcnt + FCNT_W'(1);
              state <= FCHK;
            end
          end
        end
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  // State-decoded memory/array controls; fill/valid/dirty strobes follow !dwait.
  always_comb begin
    rd_idx    = '0;
    rd_way    = 1'b0;
    dREN      = 1'b0;
    dWEN      = 1'b0;
    daddr     = '0;
    dstore    = '0;
    fill_en   = 1'b0;
    fill_off  = 1'b0;
    fill_data = '0;
    fill_tag  = '0;
    set_valid = 1'b0;
    clr_dirty = 1'b0;
    flushed   = 1'b0;
    case (state)
      IDLE: begin
        rd_idx = req.idx;
        rd_way = lru[req.idx];
      end
      WB0, WB1: begin
        rd_idx = req.idx;
        rd_way = vway;
        dWEN   = 1'b1;
        daddr  = {vic_tag, req.idx, (state == WB1), 2'b00};
        dstore = (state == WB1) ? vic_data1 : vic_data0;
      end
      LD0, LD1: begin
        rd_idx    = req.idx;
        rd_way    = vway;
        dREN      = 1'b1;
        daddr     = {req.tag, req.idx, (state == LD1), 2'b00};
        fill_en   = !dwait;
        fill_off  = (state == LD1);
        fill_data = dload;
        if (state == LD1) begin
          fill_tag  = req.tag;
          set_valid = !dwait;
          clr_dirty = !dwait;
        end
      end
      FCHK: begin
        rd_idx = fcnt[IDX_W-1:0];
        rd_way = fcnt[FCNT_W-1];
      end
      FWB0, FWB1: begin
        rd_idx    = fcnt[IDX_W-1:0];
        rd_way    = fcnt[FCNT_W-1];
        dWEN      = 1'b1;
        daddr     = {vic_tag, fcnt[IDX_W-1:0], (state == FWB1), 2'b00};
        dstore    = (state == FWB1) ? vic_data1 : vic_data0;
        clr_dirty = (state == FWB1) && !dwait;
      end
      DONE:    flushed = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed bench for dcache_miss_ctrl; a small frame array answers rd_idx/rd_way.
module tb_dcache_miss_ctrl;

  logic        CLK, RST;
  logic        dmemREN, dmemWEN, miss, setsel, halt;
  logic [31:0] dmemaddr;
  logic [2:0]  rd_idx;
  logic        rd_way;
  logic        vic_valid, vic_dirty;
  logic [25:0] vic_tag;
  logic [31:0] vic_data0, vic_data1;
  logic        dREN, dWEN;
  logic [31:0] daddr, dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        fill_en, fill_off;
  logic [31:0] fill_data;
  logic [25:0] fill_tag;
  logic        set_valid, clr_dirty, flushed;

  int checks = 0;
  int errors = 0;

  // Frame array indexed by {way, idx}
  logic        fv [16];
  logic        fd [16];
  logic [25:0] ft [16];
  logic [31:0] f0 [16];
  logic [31:0] f1 [16];

  assign vic_valid = fv[{rd_way, rd_idx}];
  assign vic_dirty = fd[{rd_way, rd_idx}];
  assign vic_tag   = ft[{rd_way, rd_idx}];
  assign vic_data0 = f0[{rd_way, rd_idx}];
  assign vic_data1 = f1[{rd_way, rd_idx}];

  dcache_miss_ctrl dut (
    .CLK(CLK), .RST(RST), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .miss(miss), .setsel(setsel), .halt(halt),
    .rd_idx(rd_idx), .rd_way(rd_way), .vic_valid(vic_valid),
    .vic_dirty(vic_dirty), .vic_tag(vic_tag), .vic_data0(vic_data0),
    .vic_data1(vic_data1), .dREN(dREN), .dWEN(dWEN), .daddr(daddr),
    .dstore(dstore), .dwait(dwait), .dload(dload), .fill_en(fill_en),
    .fill_off(fill_off), .fill_data(fill_data), .fill_tag(fill_tag),
    .set_valid(set_valid), .clr_dirty(clr_dirty), .flushed(flushed)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_frames();
    for (int i = 0; i < 16; i++) begin
      fv[i] = 1'b0; fd[i] = 1'b0; ft[i] = '0; f0[i] = '0; f1[i] = '0;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) tick();
    RST = 1'b0;
    dmemaddr = 32'h0000_0048;
    #1;
    checks++; if (rd_idx !== 3'd1) begin errors++; $display("FAIL reset_rd_idx got %0d exp 1", rd_idx); end
    checks++; if (rd_way !== 1'b0) begin errors++; $display("FAIL reset_rd_way got %0b exp 0", rd_way); end
    checks++; if ({dREN, dWEN, fill_en, set_valid, clr_dirty, flushed} !== 6'b0)
      begin errors++; $display("FAIL reset_outs got %b exp 000000", {dREN, dWEN, fill_en, set_valid, clr_dirty, flushed}); end
    checks++; if (daddr !== 32'h0) begin errors++; $display("FAIL reset_daddr got %h exp 0", daddr); end
  endtask

  task automatic test_clean_miss();
    dmemaddr = 32'h0000_0048; dmemREN = 1'b1; miss = 1'b1; dwait = 1'b1;
    #1;
    checks++; if (dREN !== 1'b0) begin errors++; $display("FAIL cm_idle_dren got %b exp 0", dREN); end
    tick();
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if ({dREN, dWEN, fill_en} !== 3'b100 || daddr !== 32'h48)
        begin errors++; $display("FAIL cm_ld0_stall got ren/wen/fill %b addr %h exp 100 48", {dREN, dWEN, fill_en}, daddr); end
      tick();
    end
    dwait = 1'b0; dload = 32'hAAAA_0001;
    #1;
    checks++; if ({fill_en, fill_off, set_valid} !== 3'b100 || fill_data !== 32'hAAAA_0001)
      begin errors++; $display("FAIL cm_fill0 got en/off/sv %b data %h exp 100 aaaa0001", {fill_en, fill_off, set_valid}, fill_data); end
    tick();
    dwait = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if ({dREN, dWEN, fill_en, set_valid} !== 4'b1000 || daddr !== 32'h4C)
        begin errors++; $display("FAIL cm_ld1_stall got %b addr %h exp 1000 4c", {dREN, dWEN, fill_en, set_valid}, daddr); end
      tick();
    end
    dwait = 1'b0; dload = 32'hAAAA_0002; miss = 1'b0; setsel = 1'b0;
    #1;
    checks++; if ({fill_en, fill_off, set_valid, clr_dirty} !== 4'b1111 || fill_data !== 32'hAAAA_0002)
      begin errors++; $display("FAIL cm_fill1 got %b data %h exp 1111 aaaa0002", {fill_en, fill_off, set_valid, clr_dirty}, fill_data); end
    checks++; if (fill_tag !== 26'h1) begin errors++; $display("FAIL cm_fill_tag got %h exp 1", fill_tag); end
    tick();
    #1;
    checks++; if ({dREN, dWEN, fill_en} !== 3'b000 || rd_idx !== 3'd1)
      begin errors++; $display("FAIL cm_back_idle got %b idx %0d exp 000 1", {dREN, dWEN, fill_en}, rd_idx); end
    tick();
    dmemREN = 1'b0;
  endtask

  task automatic test_dirty_victim();
    fv[2] = 1'b1; fd[2] = 1'b1; ft[2] = 26'h5; f0[2] = 32'h11; f1[2] = 32'h22;
    dmemaddr = 32'h0000_0050; dmemREN = 1'b1; miss = 1'b1; dwait = 1'b0;
    #1;
    checks++; if (rd_idx !== 3'd2 || rd_way !== 1'b0)
      begin errors++; $display("FAIL dv_select got idx %0d way %0b exp 2 0", rd_idx, rd_way); end
    tick();
    miss = 1'b0;
    #1;
    checks++; if ({dWEN, dREN} !== 2'b10 || daddr !== 32'h150 || dstore !== 32'h11)
      begin errors++; $display("FAIL dv_wb0 got wen/ren %b addr %h data %h exp 10 150 11", {dWEN, dREN}, daddr, dstore); end
    tick();
    #1;
    checks++; if ({dWEN, dREN} !== 2'b10 || daddr !== 32'h154 || dstore !== 32'h22)
      begin errors++; $display("FAIL dv_wb1 got wen/ren %b addr %h data %h exp 10 154 22", {dWEN, dREN}, daddr, dstore); end
    tick();
    #1;
    checks++; if ({dWEN, dREN} !== 2'b01 || daddr !== 32'h50)
      begin errors++; $display("FAIL dv_ld0 got wen/ren %b addr %h exp 01 50", {dWEN, dREN}, daddr); end
    tick();
    #1;
    checks++; if ({dWEN, dREN, set_valid} !== 3'b011 || daddr !== 32'h54)
      begin errors++; $display("FAIL dv_ld1 got %b addr %h exp 011 54", {dWEN, dREN, set_valid}, daddr); end
    tick();
    dmemREN = 1'b0;
    #1;
    checks++; if ({dWEN, dREN} !== 2'b00) begin errors++; $display("FAIL dv_idle got %b exp 00", {dWEN, dREN}); end
  endtask

  task automatic test_lru();
    dmemaddr = 32'h0000_0018; dmemREN = 1'b1; miss = 1'b0; setsel = 1'b0; dwait = 1'b0;
    #1;
    checks++; if (rd_way !== 1'b0) begin errors++; $display("FAIL lru3_init got %b exp 0", rd_way); end
    tick();
    setsel = 1'b1;
    #1;
    checks++; if (rd_way !== 1'b1) begin errors++; $display("FAIL lru3_after_hit0 got %b exp 1", rd_way); end
    tick();
    miss = 1'b1;
    #1;
    checks++; if (rd_way !== 1'b0) begin errors++; $display("FAIL lru3_after_hit1 got %b exp 0", rd_way); end
    tick();
    miss = 1'b0; dmemREN = 1'b0;
    #1;
    checks++; if ({dREN, dWEN} !== 2'b10 || rd_way !== 1'b0 || daddr !== 32'h18)
      begin errors++; $display("FAIL lru3_evict got ren/wen %b way %b addr %h exp 10 0 18", {dREN, dWEN}, rd_way, daddr); end
    tick();
    tick();
  endtask

  task automatic test_rst_mid();
    fv[9] = 1'b0;
    dmemaddr = 32'h0000_0048; dmemREN = 1'b1; miss = 1'b1; dwait = 1'b1;
    #1;
    checks++; if (rd_way !== 1'b1) begin errors++; $display("FAIL rst_pre_lru got %b exp 1", rd_way); end
    tick();
    miss = 1'b0; dmemREN = 1'b0;
    #1;
    checks++; if (dREN !== 1'b1 || rd_way !== 1'b1)
      begin errors++; $display("FAIL rst_ld0 got ren %b way %b exp 1 1", dREN, rd_way); end
    RST = 1'b1;
    tick();
    #1;
    checks++; if ({dREN, dWEN, fill_en} !== 3'b000)
      begin errors++; $display("FAIL rst_dren_drop got %b exp 000", {dREN, dWEN, fill_en}); end
    RST = 1'b0;
    dwait = 1'b0;
    #1;
    checks++; if (rd_way !== 1'b0 || rd_idx !== 3'd1)
      begin errors++; $display("FAIL rst_lru_clear got way %b idx %0d exp 0 1", rd_way, rd_idx); end
    tick();
    #1;
    checks++; if (dREN !== 1'b0) begin errors++; $display("FAIL rst_idle_dren got %b exp 0", dREN); end
  endtask

  task automatic test_halt_flush();
    logic [31:0] wa [8];
    logic [31:0] wd [8];
    logic [31:0] exp_a [4];
    logic [31:0] exp_d [4];
    int nw, nren, ncd, cyc;
    bit seen;
    clear_frames();
    fv[4]  = 1'b1; fd[4]  = 1'b1; ft[4]  = 26'hA; f0[4]  = 32'h41; f1[4]  = 32'h42;
    fv[15] = 1'b1; fd[15] = 1'b1; ft[15] = 26'hB; f0[15] = 32'h71; f1[15] = 32'h72;
    fv[5]  = 1'b1; fd[5]  = 1'b0; ft[5]  = 26'hC;
    exp_a[0] = 32'h2A0; exp_a[1] = 32'h2A4; exp_a[2] = 32'h2F8; exp_a[3] = 32'h2FC;
    exp_d[0] = 32'h41;  exp_d[1] = 32'h42;  exp_d[2] = 32'h71;  exp_d[3] = 32'h72;
    nw = 0; nren = 0; ncd = 0; cyc = 0; seen = 1'b0;
    dmemaddr = 32'h0000_0048; dmemREN = 1'b1; miss = 1'b1; halt = 1'b1; dwait = 1'b0;
    while (!seen && cyc < 100) begin
      #1;
      if (flushed) begin
        seen = 1'b1;
      end else begin
        if (dREN) nren++;
        if (dWEN && !dwait && nw < 8) begin wa[nw] = daddr; wd[nw] = dstore; nw++; end
        if (clr_dirty) ncd++;
        tick();
        miss = 1'b0; dmemREN = 1'b0;
        cyc++;
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL flush_timeout got cycles %0d exp flushed", cyc); end
    checks++; if (cyc !== 21) begin errors++; $display("FAIL flush_cycles got %0d exp 21", cyc); end
    checks++; if (nren !== 0) begin errors++; $display("FAIL flush_no_refill got dREN cycles %0d exp 0", nren); end
    checks++; if (nw !== 4) begin errors++; $display("FAIL flush_wb_count got %0d exp 4", nw); end
    checks++; if (ncd !== 2) begin errors++; $display("FAIL flush_clr_dirty got %0d exp 2", ncd); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= nw || wa[i] !== exp_a[i] || wd[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL flush_wb%0d got addr %h data %h exp %h %h", i, wa[i], wd[i], exp_a[i], exp_d[i]);
      end
    end
    halt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      checks++; if ({flushed, dREN, dWEN} !== 3'b100)
        begin errors++; $display("FAIL flush_sticky%0d got %b exp 100", k, {flushed, dREN, dWEN}); end
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    checks++; if (flushed !== 1'b0) begin errors++; $display("FAIL flush_rst got %b exp 0", flushed); end
  endtask

  initial begin
    RST = 1'b1; dmemREN = 1'b0; dmemWEN = 1'b0; dmemaddr = '0; miss = 1'b0;
    setsel = 1'b0; halt = 1'b0; dwait = 1'b0; dload = '0;
    clear_frames();
    test_reset();
    test_clean_miss();
    test_dirty_victim();
    test_lru();
    test_rst_mid();
    test_halt_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
